multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles per instruction.
- Stalls on a memory ready handshake.
- Drives every datapath select and write enable, plus the 3-bit ALU control derived from aluop and funct.
- Sits between the instruction register and the shared ALU / unified memory / register file.

Parameters:
- STATE_W, 4, width of the state register.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pcen  out  1  PC write enable; equals pcwrite | (branch & zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- regdst  out  1  destination register: 0 = rt, 1 = rd.
- memtoreg  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A operand: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B operand: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal  out  1  one-cycle pulse for an unsupported opcode.
- state_o  out  STATE_W  current state, for debug.

Behaviour:
- Supported opcodes: R-type 000000 (add/sub/and/or/slt), lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Reset:
  - On rst_n low: state=FETCH immediately (async).
  - While rst_n is low, all write enables (pcen, irwrite, memwrite, regwrite) and illegal are forced to 0.
  - Select outputs take their FETCH values: iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=010.
  - Reset asserted mid-instruction aborts it with no further writes.
- FETCH:
  - Outputs: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite = pcwrite = mem_ready.
  - Stays in FETCH while mem_ready=0.
  - mem_ready=1: go to DECODE.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
  - Next state by opcode: lw/sw -> MEMADR, R-type -> EXEC, beq -> BRANCH, addi -> ADDIEX, j -> JUMP.
  - Any other opcode: illegal=1 for this cycle, then FETCH.
- MEMADR:
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD:
  - Outputs: iord=1.
  - Waits for mem_ready, then MEMWB.
- MEMWB:
  - Outputs: regdst=0, memtoreg=1, regwrite=1.
  - Next: FETCH.
- MEMWR:
  - Outputs: iord=1, memwrite=1, held until mem_ready.
  - Next: FETCH on mem_ready.
- EXEC:
  - Outputs: alusrca=1, alusrcb=00, aluop=10.
  - Next: ALUWB.
- ALUWB:
  - Outputs: regdst=1, memtoreg=0, regwrite=1.
  - Next: FETCH.
- BRANCH:
  - Outputs: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - pcen = zero.
  - Next: FETCH.
- ADDIEX:
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Next: ADDIWB.
- ADDIWB:
  - Outputs: regdst=0, memtoreg=0, regwrite=1.
  - Next: FETCH.
- JUMP:
  - Outputs: pcsrc=10, pcwrite=1.
  - Next: FETCH.
- Output defaults: any output not named for a state is 0 in that state.
- alucontrol mapping:
  - aluop 00 -> 010; aluop 01 -> 110.
  - aluop 10 -> decoded from funct; an unknown funct gives 000.
  - In states with no ALU use, alucontrol=010.
- Cycle counts (mem_ready tied high): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; illegal opcode takes 2 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Timing style: all outputs are combinational from state; only pcen, irwrite and memwrite gating also depend on zero and mem_ready. No registered outputs.
- Unused states 12-15: outputs at defaults, next state FETCH.

Decomposition:
- Shared package mips_ctrl_pkg:
  - Opcode constants.
  - State encoding localparams.
  - aluop codes (00/01/10).
  - alucontrol codes.
  - alusrcb and pcsrc select codes.
- One sub-module: the team's existing alu_decoder (funct, aluop -> alucontrol), instantiated unchanged.
- FSM next-state and output logic stay in this module.

Test Plan:
- Reset: assert rst_n=0 mid-MEMWR -> state_o=0 and memwrite=0 at once; after release, FETCH with alusrcb=01.
- lw, opcode 100011, mem_ready=1 -> states 0,1,2,3,4, then 0; regwrite=1 and memtoreg=1 only in the 5th cycle.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite held 4 cycles; exactly one FETCH follows.
- R-type sub, funct 100010 -> alucontrol=110 in EXEC; regdst=1 and regwrite=1 in ALUWB.
- beq with zero=1 -> pcen=1 in BRANCH; with zero=0 -> pcen=0; alucontrol=110 in both cases.
- Opcode 111111 -> illegal pulses for 1 cycle in DECODE, then FETCH; no write enable ever asserted.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// ALU operation classes and datapath mux select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU operation class and the R-type funct field to the
// 3-bit ALU control word.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle MIPS datapath. Outputs decode directly from
// the state; only the write enables also look at zero, mem_ready and reset.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcen,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  state_e     state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite, branch;
  logic       memwrite_s, irwrite_s, regwrite_s, illegal_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PCSRC_ALU;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    illegal_s  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        irwrite_s = mem_ready;
        pcwrite   = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        alusrcb = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_s = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (alucontrol)
  );

  // Reset is asynchronous, so the strobes are masked combinationally as well.
  assign pcen     = rst_n & (pcwrite | (branch & zero));
  assign irwrite  = rst_n & irwrite_s;
  assign memwrite = rst_n & memwrite_s;
  assign regwrite = rst_n & regwrite_s;
  assign illegal  = rst_n & illegal_s;
  assign state_o  = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven check of the multi-cycle controller, plus a
// hand-written async reset sequence aborting a stalled store.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state_o(state_o)
  );

  // {pcen,iord,memwrite,irwrite}_{regdst,memtoreg,regwrite,alusrca}_{alusrcb,pcsrc}_{alucontrol,illegal}
  logic [15:0] outs;
  assign outs = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, alucontrol, illegal};

  localparam logic [15:0] O_FETCH   = 16'b1001_0000_0100_0100;
  localparam logic [15:0] O_FSTALL  = 16'b0000_0000_0100_0100;
  localparam logic [15:0] O_DECODE  = 16'b0000_0000_1100_0100;
  localparam logic [15:0] O_ILLEGAL = 16'b0000_0000_1100_0101;
  localparam logic [15:0] O_MEMADR  = 16'b0000_0001_1000_0100;
  localparam logic [15:0] O_MEMRD   = 16'b0100_0000_0000_0100;
  localparam logic [15:0] O_MEMWB   = 16'b0000_0110_0000_0100;
  localparam logic [15:0] O_MEMWR   = 16'b0110_0000_0000_0100;
  localparam logic [15:0] O_EX_ADD  = 16'b0000_0001_0000_0100;
  localparam logic [15:0] O_EX_SUB  = 16'b0000_0001_0000_1100;
  localparam logic [15:0] O_EX_AND  = 16'b0000_0001_0000_0000;
  localparam logic [15:0] O_EX_OR   = 16'b0000_0001_0000_0010;
  localparam logic [15:0] O_EX_SLT  = 16'b0000_0001_0000_1110;
  localparam logic [15:0] O_ALUWB   = 16'b0000_1010_0000_0100;
  localparam logic [15:0] O_BR_T    = 16'b1000_0001_0001_1100;
  localparam logic [15:0] O_BR_NT   = 16'b0000_0001_0001_1100;
  localparam logic [15:0] O_ADDIEX  = 16'b0000_0001_1000_0100;
  localparam logic [15:0] O_ADDIWB  = 16'b0000_0010_0000_0100;
  localparam logic [15:0] O_JUMP    = 16'b1000_0000_0010_0100;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] out;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [3:0] st,
                     input logic [15:0] out);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] exp_st, input logic [15:0] exp_out);
    n_checks++;
    if (state_o === exp_st && outs === exp_out) begin
      n_pass++;
      $display("ok   %-14s state=%0d outs=%b", name, state_o, outs);
    end else begin
      $display("FAIL %-14s state got %0d want %0d, outs got %b want %b",
               name, state_o, exp_st, outs, exp_out);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

    // lw: 5 cycles
    add("lw_fetch",  LW, 6'd0, 0, 1, 4'd0, O_FETCH);
    add("lw_decode", LW, 6'd0, 0, 1, 4'd1, O_DECODE);
    add("lw_memadr", LW, 6'd0, 0, 1, 4'd2, O_MEMADR);
    add("lw_memrd",  LW, 6'd0, 0, 1, 4'd3, O_MEMRD);
    add("lw_memwb",  LW, 6'd0, 0, 1, 4'd4, O_MEMWB);
    // sw, three stall cycles in MEMWR
    add("sw_fetch",  SW, 6'd0, 0, 1, 4'd0, O_FETCH);
    add("sw_decode", SW, 6'd0, 0, 1, 4'd1, O_DECODE);
    add("sw_memadr", SW, 6'd0, 0, 1, 4'd2, O_MEMADR);
    add("sw_wr_st1", SW, 6'd0, 0, 0, 4'd5, O_MEMWR);
    add("sw_wr_st2", SW, 6'd0, 0, 0, 4'd5, O_MEMWR);
    add("sw_wr_st3", SW, 6'd0, 0, 0, 4'd5, O_MEMWR);
    add("sw_wr_done", SW, 6'd0, 0, 1, 4'd5, O_MEMWR);
    // R-type sub
    add("sub_fetch", RT, 6'b100010, 0, 1, 4'd0, O_FETCH);
    add("sub_decode", RT, 6'b100010, 0, 1, 4'd1, O_DECODE);
    add("sub_exec",  RT, 6'b100010, 0, 1, 4'd6, O_EX_SUB);
    add("sub_aluwb", RT, 6'b100010, 0, 1, 4'd7, O_ALUWB);
    // remaining funct codes, FETCH held by a one-cycle memory stall
    add("add_fstall", RT, 6'b100000, 0, 0, 4'd0, O_FSTALL);
    add("add_fetch", RT, 6'b100000, 0, 1, 4'd0, O_FETCH);
    add("add_decode", RT, 6'b100000, 0, 1, 4'd1, O_DECODE);
    add("add_exec",  RT, 6'b100000, 0, 1, 4'd6, O_EX_ADD);
    add("add_aluwb", RT, 6'b100000, 0, 1, 4'd7, O_ALUWB);
    add("and_fetch", RT, 6'b100100, 0, 1, 4'd0, O_FETCH);
    add("and_decode", RT, 6'b100100, 0, 1, 4'd1, O_DECODE);
    add("and_exec",  RT, 6'b100100, 0, 1, 4'd6, O_EX_AND);
    add("and_aluwb", RT, 6'b100100, 0, 1, 4'd7, O_ALUWB);
    add("or_fetch",  RT, 6'b100101, 0, 1, 4'd0, O_FETCH);
    add("or_decode", RT, 6'b100101, 0, 1, 4'd1, O_DECODE);
    add("or_exec",   RT, 6'b100101, 0, 1, 4'd6, O_EX_OR);
    add("or_aluwb",  RT, 6'b100101, 0, 1, 4'd7, O_ALUWB);
    add("slt_fetch", RT, 6'b101010, 0, 1, 4'd0, O_FETCH);
    add("slt_decode", RT, 6'b101010, 0, 1, 4'd1, O_DECODE);
    add("slt_exec",  RT, 6'b101010, 0, 1, 4'd6, O_EX_SLT);
    add("slt_aluwb", RT, 6'b101010, 0, 1, 4'd7, O_ALUWB);
    add("unk_fetch", RT, 6'b000000, 0, 1, 4'd0, O_FETCH);
    add("unk_decode", RT, 6'b000000, 0, 1, 4'd1, O_DECODE);
    add("unk_exec",  RT, 6'b000000, 0, 1, 4'd6, O_EX_AND);
    add("unk_aluwb", RT, 6'b000000, 0, 1, 4'd7, O_ALUWB);
    // beq taken / not taken
    add("beqt_fetch", BEQ, 6'd0, 1, 1, 4'd0, O_FETCH);
    add("beqt_decode", BEQ, 6'd0, 1, 1, 4'd1, O_DECODE);
    add("beqt_branch", BEQ, 6'd0, 1, 1, 4'd8, O_BR_T);
    add("beqn_fetch", BEQ, 6'd0, 0, 1, 4'd0, O_FETCH);
    add("beqn_decode", BEQ, 6'd0, 0, 1, 4'd1, O_DECODE);
    add("beqn_branch", BEQ, 6'd0, 0, 1, 4'd8, O_BR_NT);
    // addi, lw with a read stall, j, illegal
    add("addi_fetch", ADDI, 6'd0, 0, 1, 4'd0, O_FETCH);
    add("addi_decode", ADDI, 6'd0, 0, 1, 4'd1, O_DECODE);
    add("addi_ex",   ADDI, 6'd0, 0, 1, 4'd9, O_ADDIEX);
    add("addi_wb",   ADDI, 6'd0, 0, 1, 4'd10, O_ADDIWB);
    add("lws_fetch", LW, 6'd0, 0, 1, 4'd0, O_FETCH);
    add("lws_decode", LW, 6'd0, 0, 1, 4'd1, O_DECODE);
    add("lws_memadr", LW, 6'd0, 0, 1, 4'd2, O_MEMADR);
    add("lws_rd_st", LW, 6'd0, 0, 0, 4'd3, O_MEMRD);
    add("lws_rd",    LW, 6'd0, 0, 1, 4'd3, O_MEMRD);
    add("lws_wb",    LW, 6'd0, 0, 1, 4'd4, O_MEMWB);
    add("j_fetch",   JMP, 6'd0, 0, 1, 4'd0, O_FETCH);
    add("j_decode",  JMP, 6'd0, 0, 1, 4'd1, O_DECODE);
    add("j_jump",    JMP, 6'd0, 0, 1, 4'd11, O_JUMP);
    add("bad_fetch", BAD, 6'd0, 0, 1, 4'd0, O_FETCH);
    add("bad_decode", BAD, 6'd0, 0, 1, 4'd1, O_ILLEGAL);
    add("bad_next",  BAD, 6'd0, 0, 0, 4'd0, O_FSTALL);

    // reset state, even with mem_ready high
    #2;
    check("reset_hold", 4'd0, O_FSTALL);
    step();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z; mem_ready = vecs[i].mr;
      @(negedge clk);
      check(vecs[i].name, vecs[i].st, vecs[i].out);
      step();
    end

    // async reset aborting a stalled store
    opcode = SW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    step();
    @(negedge clk);
    check("rst_pre_memwr", 4'd5, O_MEMWR);
    mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("rst_abort", 4'd0, O_FSTALL);
    step();
    check("rst_held", 4'd0, O_FSTALL);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1 check("rst_release", 4'd0, O_FSTALL);
    mem_ready = 1'b1;
    #1 check("rst_fetch", 4'd0, O_FETCH);
    step();
    check("rst_decode", 4'd1, O_DECODE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
